// File: rtl/fpu_arbiter_if.sv
// rtl/fpu_arbiter_if.sv - requester and FPU-side signal bundle for fpu_arbiter
// master: requesters plus FPU (testbench side); slave: the arbiter itself.
interface fpu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req;
  logic [5*NREQ-1:0]    req_ctl;
  logic [32*NREQ-1:0]   req_x1;
  logic [32*NREQ-1:0]   req_x2;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_y;
  logic                 rsp_err;
  logic                 busy;
  logic [4:0]           fpu_ctl;
  logic [31:0]          fpu_x1;
  logic [31:0]          fpu_x2;
  logic                 fpu_en;
  logic                 fpu_ready;
  logic [31:0]          fpu_y;

  modport master (
    output req, req_ctl, req_x1, req_x2, fpu_ready, fpu_y,
    input  gnt, rsp_valid, rsp_y, rsp_err, busy, fpu_ctl, fpu_x1, fpu_x2, fpu_en
  );

  modport slave (
    input  req, req_ctl, req_x1, req_x2, fpu_ready, fpu_y,
    output gnt, rsp_valid, rsp_y, rsp_err, busy, fpu_ctl, fpu_x1, fpu_x2, fpu_en
  );
endinterface

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin arbiter sharing one FPU between NREQ requesters
// Optional WAIT-state watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_w;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_rr_next;
  logic            w_any;
  logic            w_illegal;
  logic            w_tmo;
  logic [4:0]      w_win_ctl;
  logic [31:0]     w_win_x1;
  logic [31:0]     w_win_x2;
  logic [4:0]      r_ctl;
  logic [31:0]     r_x1;
  logic [31:0]     r_x2;
  logic [31:0]     r_y;
  logic            r_err;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from the highest offset down so the nearest requester at/after r_rr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(r_rr, i)]) begin
        w_any = 1'b1;
        w_win = wrap_add(r_rr, i);
      end
    end
  end

  assign w_win_ctl = bus.req_ctl[int'(w_win)*5 +: 5];
  assign w_win_x1  = bus.req_x1[int'(w_win)*32 +: 32];
  assign w_win_x2  = bus.req_x2[int'(w_win)*32 +: 32];
  assign w_illegal = (w_win_ctl > 5'd20);
  assign w_rr_next = wrap_add(w_win, 1);

`ifdef FPU_ARB_TIMEOUT_EN
  logic [5:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 6'd1;
    end
  end

  assign w_tmo = (r_state == S_WAIT) && (r_cnt == 6'(TIMEOUT - 1));
`else
  assign w_tmo = (TIMEOUT < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (bus.fpu_ready || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_w     <= '0;
      r_ctl   <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Operands latch only on a grant so the FPU sees them stable until RESP.
      if (r_state == S_IDLE && w_any) begin
        r_w   <= w_win;
        r_rr  <= w_rr_next;
        r_ctl <= w_win_ctl;
        r_x1  <= w_win_x1;
        r_x2  <= w_win_x2;
        r_y   <= '0;
        r_err <= w_illegal;
      end
      if (r_state == S_WAIT) begin
        if (bus.fpu_ready) begin
          r_y   <= bus.fpu_y;
          r_err <= 1'b0;
        end else if (w_tmo) begin
          r_y   <= '0;
          r_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (r_state == S_IDLE && w_any) bus.gnt[w_win] = 1'b1;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (r_state == S_RESP) bus.rsp_valid[r_w] = 1'b1;
  end

  assign bus.rsp_y   = r_y;
  assign bus.rsp_err = r_err;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.fpu_en  = (r_state == S_ISSUE);
  assign bus.fpu_ctl = r_ctl;
  assign bus.fpu_x1  = r_x1;
  assign bus.fpu_x2  = r_x2;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - scoreboard bench for fpu_arbiter with a stub FPU
// Reference model: pending-request set, round-robin pointer and per-op latency table.
module tb_fpu_arbiter;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_arbiter_if #(.NREQ(NREQ)) bus ();

  fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(31)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub FPU pipeline depth per op code.
  function automatic int lat_of(input logic [4:0] c);
    case (c)
      5'd0:    return 4;
      5'd2:    return 2;
      5'd4:    return 8;
      5'd12:   return 0;
      default: return int'(c) % 5;
    endcase
  endfunction

  // Stub FPU result: exact for fneg and the 1.0+2.0 fadd, a deterministic scramble otherwise.
  function automatic logic [31:0] fpu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 5'd12) return a ^ 32'h8000_0000;
    if (c == 5'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return {a[15:0] ^ b[31:16], b[15:0] + a[31:16]} ^ {27'd0, c};
  endfunction

  // Stub FPU: ready N+1 edges after en; re-reads ctl/x1/x2 when it produces y.
  logic s_pend;
  int   s_rem;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.fpu_ready <= 1'b0;
      bus.fpu_y     <= '0;
      s_pend        <= 1'b0;
      s_rem         <= 0;
    end else begin
      bus.fpu_ready <= 1'b0;
      if (bus.fpu_en) begin
        if (lat_of(bus.fpu_ctl) == 0) begin
          bus.fpu_ready <= 1'b1;
          bus.fpu_y     <= fpu_fn(bus.fpu_ctl, bus.fpu_x1, bus.fpu_x2);
        end else begin
          s_pend <= 1'b1;
          s_rem  <= lat_of(bus.fpu_ctl) - 1;
        end
      end else if (s_pend) begin
        if (s_rem == 0) begin
          bus.fpu_ready <= 1'b1;
          bus.fpu_y     <= fpu_fn(bus.fpu_ctl, bus.fpu_x1, bus.fpu_x2);
          s_pend        <= 1'b0;
        end else begin
          s_rem <= s_rem - 1;
        end
      end
    end
  end

  typedef struct {
    int          w;
    logic [4:0]  ctl;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        err;
    int          g;
    int          r;
  } op_t;

  op_t             q[$];
  op_t             cur;
  op_t             mo;
  bit              cur_v = 1'b0;
  int              m_rr = 0;
  int              m_free = 0;
  int              mw;
  int              mk;
  logic [NREQ-1:0] eg;
  logic [NREQ-1:0] ev;
  logic [NREQ-1:0] last_gnt = '0;
  bit              in_op;

  // Monitor / scoreboard at the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_gnt",       32'(bus.gnt), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy), 32'd0);
      chk("rst_fpu_en",    32'(bus.fpu_en), 32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_y",     bus.rsp_y, 32'd0);
      chk("rst_fpu_ctl",   32'(bus.fpu_ctl), 32'd0);
      chk("rst_fpu_x1",    bus.fpu_x1, 32'd0);
      chk("rst_fpu_x2",    bus.fpu_x2, 32'd0);
      q.delete();
      cur_v    = 1'b0;
      m_rr     = 0;
      m_free   = 0;
      last_gnt = '0;
    end else begin
      eg = '0;
      if (cyc >= m_free && |bus.req) begin
        mw = -1;
        for (int i = 0; i < NREQ; i++) begin
          mk = (m_rr + i) % NREQ;
          if (mw < 0 && bus.req[mk]) mw = mk;
        end
        eg[mw] = 1'b1;
        mo.w   = mw;
        mo.ctl = bus.req_ctl[5*mw +: 5];
        mo.x1  = bus.req_x1[32*mw +: 32];
        mo.x2  = bus.req_x2[32*mw +: 32];
        mo.err = (mo.ctl > 5'd20);
        mo.y   = mo.err ? 32'd0 : fpu_fn(mo.ctl, mo.x1, mo.x2);
        mo.g   = cyc;
        mo.r   = mo.err ? cyc + 1 : cyc + 3 + lat_of(mo.ctl);
        q.push_back(mo);
        cur    = mo;
        cur_v  = 1'b1;
        m_rr   = (mw + 1) % NREQ;
        m_free = mo.r + 1;
      end
      chk("gnt", 32'(bus.gnt), 32'(eg));
      last_gnt = bus.gnt;

      in_op = cur_v && cyc > cur.g && cyc <= cur.r;
      chk("busy",   32'(bus.busy), 32'(in_op));
      chk("fpu_en", 32'(bus.fpu_en), 32'(cur_v && cyc == cur.g + 1 && !cur.err));
      if (in_op) begin
        chk("fpu_ctl_hold", 32'(bus.fpu_ctl), 32'(cur.ctl));
        chk("fpu_x1_hold",  bus.fpu_x1, cur.x1);
        chk("fpu_x2_hold",  bus.fpu_x2, cur.x2);
      end

      if (|bus.rsp_valid || (q.size() > 0 && q[0].r <= cyc)) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          mo = q.pop_front();
          ev = '0;
          ev[mo.w] = 1'b1;
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
          chk("rsp_cycle", 32'(cyc), 32'(mo.r));
          chk("rsp_y",     bus.rsp_y, mo.y);
          chk("rsp_err",   32'(bus.rsp_err), 32'(mo.err));
        end
      end
    end
  end

  task automatic put(input int i, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.req_ctl[5*i +: 5]  = c;
    bus.req_x1[32*i +: 32] = a;
    bus.req_x2[32*i +: 32] = b;
    bus.req[i]             = 1'b1;
  endtask

  // mode 0: drop req on grant; 1: re-issue an fmul on grant; 2: random new requests.
  task automatic step(input int mode);
    logic [4:0] c;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_gnt[i]) bus.req[i] = 1'b0;
      if (mode == 1 && last_gnt[i]) put(i, 5'd2, $urandom, $urandom);
      if (mode == 2 && !bus.req[i] && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 7) == 0) c = 5'(21 + $urandom_range(0, 10));
        else c = 5'($urandom_range(0, 20));
        put(i, c, $urandom, $urandom);
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      step(0);
      n++;
    end while (!(q.size() == 0 && cyc >= m_free && bus.req == '0) && n < bound);
    if (n >= bound) chk("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  int grants;
  int n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn        = 1'b0;
    bus.req     = '0;
    bus.req_ctl = '0;
    bus.req_x1  = '0;
    bus.req_x2  = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    put(0, 5'd0, 32'h3F80_0000, 32'h4000_0000);
    wait_idle(40);
    put(1, 5'd12, 32'h3F80_0000, 32'h0);
    wait_idle(40);

    put(0, 5'd2, $urandom, $urandom);
    put(1, 5'd2, $urandom, $urandom);
    grants = 0;
    n = 0;
    while (grants < 4 && n < 100) begin
      step(1);
      grants += $countones(last_gnt);
      n++;
    end
    bus.req = '0;
    chk("fmul_grants", 32'(grants), 32'd4);
    wait_idle(40);

    put(0, 5'd25, $urandom, $urandom);
    wait_idle(40);

    put(0, 5'd4, $urandom, $urandom);
    n = 0;
    do begin
      step(0);
      n++;
    end while (last_gnt == '0 && n < 20);
    step(0);
    step(0);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    put(1, 5'd0, 32'h3F80_0000, 32'h4000_0000);
    wait_idle(40);

    repeat (600) step(2);
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
